// File: rtl/rec_tran.sv
`default_nettype none
// ============================================================================
// Module   : rec_tran
// Purpose  : 16x-oversampled OTN frame receiver with FAS hunt, byte
//            deserializer, XOR parity check and ACK/NACK return line.
// Revision : 1.0 - initial release
// ============================================================================
module rec_tran #(
  parameter int          FRAME_BYTES = 4164,
  parameter logic [47:0] FAS_PATTERN = 48'h282828F6F6F6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk_en_16_x_baud,
  input  logic       i_otn_rx_data,
  input  logic       i_arq_en,
  input  logic       i_force_nack,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_data_fas,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic       o_otn_tx_ack
);

  localparam logic [2:0]  c_st_hunt      = 3'd0;
  localparam logic [2:0]  c_st_recv      = 3'd1;
  localparam logic [2:0]  c_st_check     = 3'd2;
  localparam logic [2:0]  c_st_ack_start = 3'd3;
  localparam logic [2:0]  c_st_ack_bit   = 3'd4;
  localparam logic [2:0]  c_st_ack_stop  = 3'd5;
  // Index of the last byte after FAS (the parity byte)
  localparam logic [12:0] c_last_byte    = 13'(FRAME_BYTES - 7);

  logic [2:0]  r_state, w_next_state;
  logic [2:0]  r_sync;
  logic        r_line_prev;
  logic [3:0]  r_phase;
  logic [47:0] r_sr;
  logic [5:0]  r_hunt_cnt;
  logic [7:0]  r_byte;
  logic [2:0]  r_bit_cnt;
  logic [12:0] r_byte_cnt;
  logic [7:0]  r_parity;
  logic        r_ack;
  logic [3:0]  r_ack_cnt;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_fas;

  logic        w_line, w_sample, w_match, w_byte_done, w_ack_wrap, w_err;
  logic [7:0]  w_new_byte;

  assign w_line      = r_sync[2];
  assign w_sample    = i_sclk_en_16_x_baud && (r_phase == 4'd8);
  assign w_match     = (r_state == c_st_hunt) && (r_hunt_cnt == 6'd48) && (r_sr == FAS_PATTERN);
  assign w_byte_done = (r_state == c_st_recv) && w_sample && (r_bit_cnt == 3'd7);
  assign w_new_byte  = {w_line, r_byte[7:1]};
  assign w_ack_wrap  = i_sclk_en_16_x_baud && (r_ack_cnt == 4'd15);
  assign w_err       = (r_parity != 8'h00) || i_force_nack;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= c_st_hunt;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_hunt:      if (w_match) w_next_state = c_st_recv;
      c_st_recv:      if (w_byte_done && (r_byte_cnt == c_last_byte)) w_next_state = c_st_check;
      c_st_check:     w_next_state = i_arq_en ? c_st_ack_start : c_st_hunt;
      c_st_ack_start: if (w_ack_wrap) w_next_state = c_st_ack_bit;
      c_st_ack_bit:   if (w_ack_wrap) w_next_state = c_st_ack_stop;
      c_st_ack_stop:  if (w_ack_wrap) w_next_state = c_st_hunt;
      default:        w_next_state = c_st_hunt;
    endcase
  end

  always_comb begin
    o_frame_done = (r_state == c_st_check);
    o_frame_err  = (r_state == c_st_check) && w_err;
    case (r_state)
      c_st_ack_start: o_otn_tx_ack = 1'b0;
      c_st_ack_bit:   o_otn_tx_ack = r_ack;
      c_st_ack_stop:  o_otn_tx_ack = 1'b0;
      default:        o_otn_tx_ack = 1'b1;
    endcase
  end

  assign o_frame_data       = r_data;
  assign o_frame_data_valid = r_valid;
  assign o_frame_data_fas   = r_fas;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 3'b111;
      r_line_prev <= 1'b1;
      r_phase     <= 4'd0;
      r_sr        <= 48'd0;
      r_hunt_cnt  <= 6'd0;
      r_byte      <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 13'd0;
      r_parity    <= 8'd0;
      r_ack       <= 1'b1;
      r_ack_cnt   <= 4'd0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_fas       <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_otn_rx_data};
      r_valid <= 1'b0;
      r_fas   <= 1'b0;
      // Any transition re-centres the sampling point 8 strobes later
      if (i_sclk_en_16_x_baud) begin
        r_line_prev <= w_line;
        r_phase     <= (w_line != r_line_prev) ? 4'd0 : r_phase + 4'd1;
      end
      case (r_state)
        c_st_hunt: begin
          if (w_match) begin
            r_fas      <= 1'b1;
            r_sr       <= 48'd0;
            r_hunt_cnt <= 6'd0;
            r_byte     <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 13'd0;
            r_parity   <= 8'd0;
          end else if (w_sample) begin
            r_sr <= {w_line, r_sr[47:1]};
            if (r_hunt_cnt != 6'd48) r_hunt_cnt <= r_hunt_cnt + 6'd1;
          end
        end
        c_st_recv: begin
          if (w_sample) begin
            r_byte    <= w_new_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_data     <= w_new_byte;
              r_valid    <= 1'b1;
              r_parity   <= r_parity ^ w_new_byte;
              r_byte_cnt <= r_byte_cnt + 13'd1;
            end
          end
        end
        c_st_check: begin
          r_ack     <= ~w_err;
          r_ack_cnt <= 4'd0;
        end
        default: begin
          if (i_sclk_en_16_x_baud) r_ack_cnt <= r_ack_cnt + 4'd1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rec_tran.sv
`default_nettype none
// ============================================================================
// Module   : tb_rec_tran
// Purpose  : Directed self-checking bench for rec_tran using short frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rec_tran;

  localparam int FB   = 12;
  localparam int NPAY = FB - 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       line = 1'b1;
  logic       arq = 1'b1;
  logic       fnack = 1'b0;
  logic [7:0] data;
  logic       valid, fas, done, err, ack;

  rec_tran #(.FRAME_BYTES(FB)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_sclk_en_16_x_baud (stb),
    .i_otn_rx_data       (line),
    .i_arq_en            (arq),
    .i_force_nack        (fnack),
    .o_frame_data        (data),
    .o_frame_data_valid  (valid),
    .o_frame_data_fas    (fas),
    .o_frame_done        (done),
    .o_frame_err         (err),
    .o_otn_tx_ack        (ack)
  );

  always #5 clk = ~clk;

  // Strobe is high on every other rising edge
  initial forever begin
    @(negedge clk);
    stb = ~stb;
  end

  int         scnt = 0;
  logic [7:0] rx_q[$];
  int         fas_cnt = 0, fas_pos = -1, done_cnt = 0, done_scnt = 0, ack_low = 0;
  logic       last_err = 1'b0;

  always @(posedge clk) if (stb) scnt <= scnt + 1;

  always @(negedge clk) begin
    if (valid) rx_q.push_back(data);
    if (fas) begin
      fas_cnt <= fas_cnt + 1;
      fas_pos <= rx_q.size();
    end
    if (done) begin
      done_cnt  <= done_cnt + 1;
      last_err  <= err;
      done_scnt <= scnt;
    end
    if (!ack) ack_low <= ack_low + 1;
  end

  int n_cmp = 0, n_fail = 0;
  logic [7:0] fr [FB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!stb) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      wait_stb(16);
    end
  endtask

  task automatic build(input logic [7:0] start, input logic flip);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 3; i++) fr[i] = 8'hF6;
    for (int i = 3; i < 6; i++) fr[i] = 8'h28;
    for (int i = 0; i < NPAY; i++) begin
      fr[6+i] = start + 8'(i);
      p = p ^ fr[6+i];
    end
    fr[FB-1] = p;
    if (flip) fr[8] = fr[8] ^ 8'h08;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_byte(fr[i]);
    line = 1'b1;
  endtask

  task automatic rx_frame(input string tag, input int base, input int dbase,
                          input int fbase, input logic exp_err);
    int t;
    logic [31:0] got;
    t = 0;
    while (done_cnt == dbase && t < 500) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk({tag, "_done"}, done_cnt, dbase + 1);
    chk({tag, "_fas"}, fas_cnt, fbase + 1);
    chk({tag, "_fas_first"}, fas_pos, base);
    chk({tag, "_nbytes"}, rx_q.size(), base + FB - 6);
    for (int i = 0; i < FB - 6; i++) begin
      got = (base + i < rx_q.size()) ? {24'd0, rx_q[base+i]} : 32'hDEAD;
      chk($sformatf("%s_byte%0d", tag, i), got, {24'd0, fr[6+i]});
    end
    chk({tag, "_err"}, last_err, exp_err);
  endtask

  task automatic wait_until(input int target);
    int t;
    t = 0;
    while (scnt < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic check_ack(input string tag, input logic bit_val);
    int s;
    s = done_scnt;
    wait_until(s + 8);
    chk({tag, "_start"}, ack, 1'b0);
    wait_until(s + 24);
    chk({tag, "_bit"}, ack, bit_val);
    wait_until(s + 40);
    chk({tag, "_stop"}, ack, 1'b0);
    wait_until(s + 56);
    chk({tag, "_idle"}, ack, 1'b1);
  endtask

  initial begin
    int base, d, f, al;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    wait_stb(100);
    chk("reset_ack", ack, 1'b1);
    chk("reset_valid_cnt", rx_q.size(), 0);
    chk("reset_fas_cnt", fas_cnt, 0);
    chk("reset_done_cnt", done_cnt, 0);
    chk("reset_data", data, 8'h00);

    // Good frame with ACK
    build(8'h00, 1'b0);
    base = rx_q.size(); d = done_cnt; f = fas_cnt;
    send_frame(FB);
    rx_frame("good", base, d, f, 1'b0);
    check_ack("good_ack", 1'b1);

    // Payload bit error -> NACK
    build(8'h10, 1'b1);
    base = rx_q.size(); d = done_cnt; f = fas_cnt;
    send_frame(FB);
    rx_frame("biterr", base, d, f, 1'b1);
    check_ack("biterr_ack", 1'b0);

    // Forced NACK on a good frame
    fnack = 1'b1;
    build(8'h20, 1'b0);
    base = rx_q.size(); d = done_cnt; f = fas_cnt;
    send_frame(FB);
    rx_frame("force", base, d, f, 1'b1);
    check_ack("force_ack", 1'b0);
    fnack = 1'b0;

    // ARQ off: no ACK activity, back-to-back frames
    arq = 1'b0;
    al  = ack_low;
    build(8'h30, 1'b0);
    base = rx_q.size(); d = done_cnt; f = fas_cnt;
    send_frame(FB);
    rx_frame("noarq1", base, d, f, 1'b0);
    build(8'h40, 1'b0);
    base = rx_q.size(); d = done_cnt; f = fas_cnt;
    send_frame(FB);
    rx_frame("noarq2", base, d, f, 1'b0);
    chk("noarq_ack_high", ack_low, al);

    // Random phase and a partial FAS ahead of the true one
    wait_stb($urandom_range(17, 47));
    base = rx_q.size(); d = done_cnt; f = fas_cnt;
    send_byte(8'hF6); send_byte(8'hF6); send_byte(8'hF6);
    send_byte(8'h28); send_byte(8'h00);
    chk("partial_no_lock", fas_cnt, f);
    build(8'h50, 1'b0);
    send_frame(FB);
    rx_frame("phase", base, d, f, 1'b0);

    // Reset in mid-frame, then a full frame
    arq = 1'b1;
    build(8'h60, 1'b0);
    base = rx_q.size();
    send_frame(8);
    for (int i = 0; i < 3; i++) begin
      line = fr[8][i];
      wait_stb(16);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ack", ack, 1'b1);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_fas", fas, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_data", data, 8'h00);
    chk("midrst_nbytes", rx_q.size(), base + 2);
    #1 rst = 1'b0;
    line = 1'b1;
    wait_stb(40);
    build(8'h70, 1'b0);
    base = rx_q.size(); d = done_cnt; f = fas_cnt;
    send_frame(FB);
    rx_frame("after_rst", base, d, f, 1'b0);
    check_ack("after_rst_ack", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
